// File: rtl/qkv_pass_scheduler.sv
// qkv_pass_scheduler: runs the Q, K and V projection passes one after another
// on the shared INT8 projection engine. Each pass selects its banks, clears and
// launches the engine, then waits for the engine to finish. A pass does not start
// while downstream still holds unconsumed results in that pass's output bank.
// A watchdog sets a sticky error if the engine hangs.
module qkv_pass_scheduler #(
  parameter int WDOG_W     = 16,
  parameter int WDOG_LIMIT = 50000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic [2:0] i_mask,
  input  logic       i_abort,
  input  logic       i_proj_finished,
  input  logic [2:0] i_bank_release,
  output logic       o_proj_clr,
  output logic       o_proj_en,
  output logic [1:0] o_wsel,
  output logic [1:0] o_osel,
  output logic       o_busy,
  output logic [2:0] o_bank_full,
  output logic       o_all_done,
  output logic       o_err_timeout
);

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_CLEAR, S_LAUNCH, S_WAIT, S_DONE, S_ERROR
  } state_t;

  localparam logic [WDOG_W-1:0] W_LIM_M1 = WDOG_W'(WDOG_LIMIT - 1);

  state_t            r_state;
  logic [2:0]        r_pending;
  logic [2:0]        r_bank_full;
  logic [1:0]        r_wsel;
  logic [1:0]        r_osel;
  logic [WDOG_W-1:0] r_wdog;
  logic              r_err;

  logic [1:0]        w_idx;
  logic [2:0]        w_onehot;
  logic              w_fin_ok;
  logic              w_stall;

  // Current pass is the lowest pending bit; Q has priority over K and K over V.
  // While in WAIT, pending is unchanged, so this still points at the running pass.
  always_comb begin
    w_idx = 2'd0;
    if (r_pending[0])      w_idx = 2'd0;
    else if (r_pending[1]) w_idx = 2'd1;
    else if (r_pending[2]) w_idx = 2'd2;
  end

  assign w_onehot = 3'b001 << w_idx;
  // An abort in the same cycle discards the finish, so bank_full does not change.
  assign w_fin_ok = (r_state == S_WAIT) && i_proj_finished && !i_abort;
  // Stall only when the bank is full and is not being released in this cycle.
  assign w_stall  = |(r_bank_full & ~i_bank_release & w_onehot);

  // Pass sequencer: state, pending mask, bank selects, watchdog and sticky error.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_pending <= 3'b000;
      r_wsel    <= 2'd0;
      r_osel    <= 2'd0;
      r_wdog    <= '0;
      r_err     <= 1'b0;
    end else if (i_abort) begin
      r_state   <= S_IDLE;
      r_pending <= 3'b000;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            if (i_mask != 3'b000) begin
              r_pending <= i_mask;
              r_state   <= S_SELECT;
            end else begin
              r_state   <= S_DONE;
            end
          end
        end
        S_SELECT: begin
          if (r_pending == 3'b000) begin
            r_state <= S_DONE;
          end else if (!w_stall) begin
            r_wsel  <= w_idx;
            r_osel  <= w_idx;
            r_state <= S_CLEAR;
          end
        end
        S_CLEAR:  r_state <= S_LAUNCH;
        S_LAUNCH: begin
          r_wdog  <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          r_wdog <= r_wdog + 1'b1;
          // A finish on the limit cycle counts as success.
          if (i_proj_finished) begin
            r_pending <= r_pending & ~w_onehot;
            r_state   <= S_SELECT;
          end else if (r_wdog == W_LIM_M1) begin
            r_err   <= 1'b1;
            r_state <= S_ERROR;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        S_ERROR: r_state <= S_ERROR;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Output-bank occupancy. A finish sets the bit even if the same bit is released
  // in that cycle. Releases are applied in every state, including during an abort.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_bank_full <= 3'b000;
    else       r_bank_full <= (r_bank_full & ~i_bank_release) | (w_fin_ok ? w_onehot : 3'b000);
  end

  assign o_proj_clr    = (r_state == S_CLEAR);
  assign o_proj_en     = (r_state == S_LAUNCH);
  assign o_busy        = (r_state != S_IDLE);
  assign o_all_done    = (r_state == S_DONE);
  assign o_wsel        = r_wsel;
  assign o_osel        = r_osel;
  assign o_bank_full   = r_bank_full;
  assign o_err_timeout = r_err;

endmodule
